// File: rtl/ysyx_22041207_ifu.sv
// Instruction fetch unit: one outstanding imem request, a single-entry holding
// register toward the decoder, and redirect handling that discards stale responses.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | just left reset, first request goes out next cycle
// REQ   | presenting pc on the imem request channel
// WAIT  | request accepted, waiting for the response word
// HOLD  | instruction captured, offered to the decoder
// DROP  | a stale request is in flight, its response is thrown away
module ysyx_22041207_ifu #(
    parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [63:0] imem_req_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [63:0] inst_pc,
    input  logic        redirect_valid,
    input  logic [63:0] redirect_pc,
    output logic        fetch_fault
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DROP
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [63:0] pc;
    logic [63:0] pc_nxt;
    logic        capture;
    logic        fault_nxt;
    logic [63:0] redirect_tgt;

    // Misaligned targets are still followed, just forced onto a word boundary.
    assign redirect_tgt = {redirect_pc[63:2], 2'b00};

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        capture   = 1'b0;
        fault_nxt = 1'b0;
        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
            end
            S_REQ: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_tgt;
                    state_nxt = imem_req_ready ? S_DROP : S_REQ;
                end else if (imem_req_ready) begin
                    state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_tgt;
                    state_nxt = imem_resp_valid ? S_REQ : S_DROP;
                end else if (imem_resp_valid) begin
                    capture   = 1'b1;
                    state_nxt = S_HOLD;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_nxt    = redirect_tgt;
                    state_nxt = S_REQ;
                end else if (inst_ready) begin
                    pc_nxt    = pc + 64'd4;
                    state_nxt = S_REQ;
                end
            end
            S_DROP: begin
                if (redirect_valid) begin
                    pc_nxt = redirect_tgt;
                end
                if (imem_resp_valid) begin
                    state_nxt = S_REQ;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
        fault_nxt = redirect_valid && (state != S_IDLE) && (redirect_pc[1:0] != 2'b00);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            inst        <= 32'h0000_0013;
            inst_pc     <= 64'd0;
            fetch_fault <= 1'b0;
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            fetch_fault <= fault_nxt;
            if (capture) begin
                inst    <= imem_resp_data;
                inst_pc <= pc;
            end
        end
    end

    assign imem_req_valid = (state == S_REQ);
    assign imem_req_addr  = pc;
    assign inst_valid     = (state == S_HOLD);

endmodule
